// File: rtl/sprite_animator.sv
// sprite_animator: frame sequencer plus a 2-stage sprite pixel pipeline (address, then key/tint)
module sprite_animator #(
    parameter int SCREEN_W = 96,
    parameter int SCREEN_H = 64,
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter int NUM_ANIMS = 4,
    parameter int FRAMES = 3,
    parameter logic [32*NUM_ANIMS-1:0] ANIM_DIV = {NUM_ANIMS{32'd25_000_000}},
    parameter logic [NUM_ANIMS-1:0] ONESHOT_MASK = 4'b0010,
    parameter logic [15:0] KEY_COLOUR = 16'hFFFF,
    localparam int AW = $clog2(NUM_ANIMS),
    localparam int FW = $clog2(FRAMES),
    localparam int RAW = $clog2(NUM_ANIMS*FRAMES*SPR_W*SPR_H)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [12:0]    pixel_index,
    input  logic [6:0]     pos_x,
    input  logic [6:0]     pos_y,
    input  logic           mirror,
    input  logic           tint_en,
    input  logic [AW-1:0]  anim_sel,
    input  logic           anim_req,
    output logic [RAW-1:0] rom_addr,
    input  logic [15:0]    rom_data,
    output logic [15:0]    pix_colour,
    output logic           pix_opaque,
    output logic [AW-1:0]  cur_anim,
    output logic [FW-1:0]  cur_frame,
    output logic           anim_done
);
    typedef enum logic {PLAY_LOOP, PLAY_ONCE} state_t;

    state_t state_q, state_d;
    logic [AW-1:0] anim_q, anim_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [31:0] cnt_q, cnt_d;
    logic done_q, done_d;
    logic [RAW-1:0] addr_q, addr_d;
    logic inside_q, inside_d;
    logic [15:0] colour_q, colour_d;
    logic opaque_q, opaque_d;
    logic sel_ok, wrap, restart;
    logic [31:0] div;
    logic [12:0] sy;
    logic signed [8:0] lx, ly, lxm;

    // Out-of-range animation numbers can only exist when NUM_ANIMS is not a power of two
    if (NUM_ANIMS == (1 << AW)) begin : g_full
        assign sel_ok = 1'b1;
    end else begin : g_part
        assign sel_ok = anim_sel < AW'(NUM_ANIMS);
    end

    // Sequencer next state: period wrap advances the frame, a valid request restarts and wins
    always_comb begin
        div = ANIM_DIV[32*anim_q +: 32];
        wrap = cnt_q == div - 32'd1;
        restart = anim_req && sel_ok && (anim_sel != anim_q || state_q == PLAY_ONCE);
        cnt_d = wrap ? '0 : cnt_q + 32'd1;
        anim_d = anim_q;
        frame_d = frame_q;
        done_d = 1'b0;
        if (wrap) begin
            if (frame_q != FW'(FRAMES-1)) begin
                frame_d = frame_q + 1'b1;
            end else begin
                frame_d = '0;
                if (state_q == PLAY_ONCE) begin
                    anim_d = '0;
                    done_d = 1'b1;
                end
            end
        end
        if (restart) begin
            anim_d = anim_sel;
            frame_d = '0;
            cnt_d = '0;
        end
        state_d = ONESHOT_MASK[anim_d] ? PLAY_ONCE : PLAY_LOOP;
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ONESHOT_MASK[0] ? PLAY_ONCE : PLAY_LOOP;
            anim_q <= '0;
            frame_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            anim_q <= anim_d;
            frame_q <= frame_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
        end
    end

    // Pixel path: signed sprite-local coordinates give natural clipping at screen edges
    always_comb begin
        sy = pixel_index / 13'(SCREEN_W);
        lx = 9'(pixel_index % 13'(SCREEN_W)) - (9'(pos_x) - 9'(SPR_W/2));
        ly = 9'(sy) - (9'(pos_y) - 9'(SPR_H/2));
        inside_d = !lx[8] && lx < 9'(SPR_W) && !ly[8] && ly < 9'(SPR_H) && sy < 13'(SCREEN_H);
        lxm = mirror ? 9'(SPR_W-1) - lx : lx;
        addr_d = inside_d ? RAW'(((int'(anim_q)*FRAMES + int'(frame_q))*SPR_H + int'(ly))*SPR_W + int'(lxm)) : '0;
        opaque_d = inside_q && rom_data != KEY_COLOUR;
        colour_d = !opaque_d ? '0 : tint_en ? {rom_data[15:11], 1'b0, rom_data[10:6], rom_data[4:0]} : rom_data;
    end

    // Pipeline registers: stage 1 holds the ROM address, stage 2 the keyed colour
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            inside_q <= 1'b0;
            colour_q <= '0;
            opaque_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            inside_q <= inside_d;
            colour_q <= colour_d;
            opaque_q <= opaque_d;
        end
    end

    assign rom_addr = addr_q;
    assign pix_colour = colour_q;
    assign pix_opaque = opaque_q;
    assign cur_anim = anim_q;
    assign cur_frame = frame_q;
    assign anim_done = done_q;
endmodule

// File: tb/tb_sprite_animator.sv
// tb_sprite_animator: directed scenarios plus randomized stimulus against a behavioural model
module tb_sprite_animator;
    localparam logic [3:0] ONESHOT = 4'b0010;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [12:0] pixel_index = '0;
    logic [6:0] pos_x = '0, pos_y = '0;
    logic mirror = 1'b0, tint_en = 1'b0, anim_req = 1'b0;
    logic [1:0] anim_sel = '0;
    logic [7:0] rom_addr;
    logic [15:0] rom_data, pix_colour;
    logic pix_opaque, anim_done;
    logic [1:0] cur_anim, cur_frame;
    logic force_en = 1'b0;
    logic [15:0] force_val = '0;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    sprite_animator #(
        .SPR_W(4), .SPR_H(4), .FRAMES(3),
        .ANIM_DIV({4{32'd4}}), .ONESHOT_MASK(4'b0010)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_index(pixel_index), .pos_x(pos_x), .pos_y(pos_y),
        .mirror(mirror), .tint_en(tint_en), .anim_sel(anim_sel), .anim_req(anim_req),
        .rom_addr(rom_addr), .rom_data(rom_data), .pix_colour(pix_colour), .pix_opaque(pix_opaque),
        .cur_anim(cur_anim), .cur_frame(cur_frame), .anim_done(anim_done)
    );

    // Sprite-sheet ROM: data equals address, address 5 holds the key colour
    function automatic logic [15:0] rom_fn(logic [7:0] a, logic fe, logic [15:0] fv);
        return fe ? fv : (a == 8'd5 ? 16'hFFFF : {8'h00, a});
    endfunction

    assign rom_data = rom_fn(rom_addr, force_en, force_val);

    // Expected address for a pixel, or -1 when outside the sprite box
    function automatic int map_fn(int p, int px, int py, logic mir, int a, int f);
        int sx, sy, lx, ly;
        sx = p % 96;
        sy = p / 96;
        lx = sx - (px - 2);
        ly = sy - (py - 2);
        if (lx < 0 || lx > 3 || ly < 0 || ly > 3) return -1;
        if (mir) lx = 3 - lx;
        return ((a * 3 + f) * 4 + ly) * 4 + lx;
    endfunction

    function automatic logic [15:0] col_fn(logic ins, logic [15:0] d, logic tint);
        if (!ins || d == 16'hFFFF) return 16'h0000;
        return tint ? ((d & 16'hF81F) | (((d >> 6) & 16'h001F) << 5)) : d;
    endfunction

    logic [1:0] m_anim;
    int m_age, mv;
    logic m_done, e_in, e_op;
    logic [7:0] e_addr;
    logic [15:0] e_col;

    always_comb mv = map_fn(int'(pixel_index), int'(pos_x), int'(pos_y), mirror, int'(m_anim), (m_age / 4) % 3);

    // Model: an animation is its number plus cycles elapsed since it started
    always @(posedge clk) begin
        if (!rst_n) begin
            m_anim <= '0; m_age <= 0; m_done <= 1'b0;
            e_addr <= '0; e_in <= 1'b0; e_col <= '0; e_op <= 1'b0;
        end else begin
            if (anim_req && (anim_sel != m_anim || ONESHOT[m_anim])) begin
                m_anim <= anim_sel; m_age <= 0; m_done <= ONESHOT[m_anim] && m_age == 11;
            end else if (ONESHOT[m_anim] && m_age == 11) begin
                m_anim <= '0; m_age <= 0; m_done <= 1'b1;
            end else begin
                m_age <= m_age + 1; m_done <= 1'b0;
            end
            e_addr <= mv < 0 ? 8'h00 : mv[7:0];
            e_in <= mv >= 0;
            e_col <= col_fn(e_in, rom_fn(e_addr, force_en, force_val), tint_en);
            e_op <= e_in && rom_fn(e_addr, force_en, force_val) != 16'hFFFF;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; anim_req = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        int exp_f;
        rst_n = 1'b0;
        repeat (3) tick;
        n_cmp++;
        if ({cur_anim, cur_frame, pix_opaque, anim_done} !== 6'b0) begin
            n_err++; $display("FAIL reset_state: anim=%0d frame=%0d opaque=%b done=%b, want all 0", cur_anim, cur_frame, pix_opaque, anim_done);
        end
        n_cmp++;
        if (rom_addr !== 8'h00 || pix_colour !== 16'h0000) begin
            n_err++; $display("FAIL reset_data: addr=%0d colour=%h, want 0", rom_addr, pix_colour);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == 3 || k == 4 || k == 8 || k == 12) begin
                exp_f = k == 4 ? 1 : k == 8 ? 2 : 0;
                n_cmp++;
                if (int'(cur_frame) !== exp_f) begin
                    n_err++; $display("FAIL reset_seq k=%0d: frame=%0d want %0d", k, cur_frame, exp_f);
                end
            end
        end
    endtask

    task automatic test_mapping;
        do_reset;
        pos_x = 7'd10; pos_y = 7'd10; mirror = 1'b0; tint_en = 1'b0;
        pixel_index = 13'(8*96+9);
        tick;
        n_cmp++;
        if (rom_addr !== 8'd1) begin
            n_err++; $display("FAIL map_addr: addr=%0d want 1", rom_addr);
        end
        tick;
        n_cmp++;
        if (pix_colour !== 16'h0001 || pix_opaque !== 1'b1) begin
            n_err++; $display("FAIL map_pix: colour=%h opaque=%b want 0001/1", pix_colour, pix_opaque);
        end
    endtask

    task automatic test_mirror_key;
        do_reset;
        pos_x = 7'd10; pos_y = 7'd10; mirror = 1'b1;
        pixel_index = 13'(8*96+9);
        tick;
        n_cmp++;
        if (rom_addr !== 8'd2) begin
            n_err++; $display("FAIL mirror_addr: addr=%0d want 2", rom_addr);
        end
        mirror = 1'b0;
        pixel_index = 13'(9*96+9);
        tick;
        n_cmp++;
        if (rom_addr !== 8'd5 || pix_colour !== 16'h0002 || pix_opaque !== 1'b1) begin
            n_err++; $display("FAIL mirror_pix: addr=%0d colour=%h opaque=%b want 5/0002/1", rom_addr, pix_colour, pix_opaque);
        end
        pixel_index = 13'(8*96+20);
        tick;
        n_cmp++;
        if (pix_opaque !== 1'b0 || pix_colour !== 16'h0000 || rom_addr !== 8'd0) begin
            n_err++; $display("FAIL key_pix: opaque=%b colour=%h addr=%0d want 0/0000/0", pix_opaque, pix_colour, rom_addr);
        end
        tick;
        n_cmp++;
        if (pix_opaque !== 1'b0) begin
            n_err++; $display("FAIL outside_pix: opaque=%b want 0", pix_opaque);
        end
    endtask

    task automatic test_oneshot;
        do_reset;
        pos_x = 7'd10; pos_y = 7'd10; mirror = 1'b0;
        pixel_index = 13'(8*96+8);
        anim_sel = 2'd1; anim_req = 1'b1;
        tick;
        anim_req = 1'b0;
        n_cmp++;
        if (cur_anim !== 2'd1 || cur_frame !== 2'd0) begin
            n_err++; $display("FAIL oneshot_start: anim=%0d frame=%0d want 1/0", cur_anim, cur_frame);
        end
        for (int k = 1; k <= 13; k++) begin
            tick;
            if (k == 4 || k == 8) begin
                n_cmp++;
                if (cur_anim !== 2'd1 || int'(cur_frame) !== k / 4) begin
                    n_err++; $display("FAIL oneshot_frame k=%0d: anim=%0d frame=%0d want 1/%0d", k, cur_anim, cur_frame, k / 4);
                end
            end
            if (k == 9) begin
                n_cmp++;
                if (rom_addr !== 8'd80) begin
                    n_err++; $display("FAIL oneshot_base: addr=%0d want 80", rom_addr);
                end
            end
            if (k == 11 || k == 13) begin
                n_cmp++;
                if (anim_done !== 1'b0) begin
                    n_err++; $display("FAIL oneshot_nodone k=%0d: done=%b want 0", k, anim_done);
                end
            end
            if (k == 12) begin
                n_cmp++;
                if (anim_done !== 1'b1 || cur_anim !== 2'd0 || cur_frame !== 2'd0) begin
                    n_err++; $display("FAIL oneshot_end: done=%b anim=%0d frame=%0d want 1/0/0", anim_done, cur_anim, cur_frame);
                end
            end
        end
    endtask

    task automatic test_priority;
        do_reset;
        anim_sel = 2'd1; anim_req = 1'b1;
        tick;
        anim_req = 1'b0;
        repeat (11) tick;
        anim_req = 1'b1;
        tick;
        anim_req = 1'b0;
        n_cmp++;
        if (anim_done !== 1'b1 || cur_anim !== 2'd1 || cur_frame !== 2'd0) begin
            n_err++; $display("FAIL prio_end: done=%b anim=%0d frame=%0d want 1/1/0", anim_done, cur_anim, cur_frame);
        end
        repeat (4) tick;
        n_cmp++;
        if (cur_anim !== 2'd1 || cur_frame !== 2'd1) begin
            n_err++; $display("FAIL prio_restart: anim=%0d frame=%0d want 1/1", cur_anim, cur_frame);
        end
        do_reset;
        repeat (2) tick;
        anim_sel = 2'd0; anim_req = 1'b1;
        tick;
        anim_req = 1'b0;
        tick;
        n_cmp++;
        if (cur_anim !== 2'd0 || cur_frame !== 2'd1) begin
            n_err++; $display("FAIL loop_rereq: anim=%0d frame=%0d want 0/1", cur_anim, cur_frame);
        end
    endtask

    task automatic test_tint_reset;
        do_reset;
        pos_x = 7'd10; pos_y = 7'd10; mirror = 1'b0;
        pixel_index = 13'(8*96+9);
        force_en = 1'b1; force_val = 16'h07E0; tint_en = 1'b1;
        repeat (2) tick;
        n_cmp++;
        if (pix_colour !== 16'h03E0 || pix_opaque !== 1'b1) begin
            n_err++; $display("FAIL tint_on: colour=%h opaque=%b want 03E0/1", pix_colour, pix_opaque);
        end
        tint_en = 1'b0;
        tick;
        n_cmp++;
        if (pix_colour !== 16'h07E0) begin
            n_err++; $display("FAIL tint_off: colour=%h want 07E0", pix_colour);
        end
        rst_n = 1'b0;
        tick;
        n_cmp++;
        if (pix_opaque !== 1'b0 || pix_colour !== 16'h0000 || rom_addr !== 8'd0) begin
            n_err++; $display("FAIL mid_reset: opaque=%b colour=%h addr=%0d want 0/0000/0", pix_opaque, pix_colour, rom_addr);
        end
        rst_n = 1'b1;
        tick;
        n_cmp++;
        if (pix_opaque !== 1'b0) begin
            n_err++; $display("FAIL release_1: opaque=%b want 0", pix_opaque);
        end
        tick;
        n_cmp++;
        if (pix_opaque !== 1'b1 || pix_colour !== 16'h07E0) begin
            n_err++; $display("FAIL release_2: opaque=%b colour=%h want 1/07E0", pix_opaque, pix_colour);
        end
        force_en = 1'b0;
    endtask

    task automatic test_random;
        int sx, sy;
        do_reset;
        for (int i = 0; i < 800; i++) begin
            pos_x = 7'($urandom_range(0, 99));
            pos_y = 7'($urandom_range(0, 67));
            sx = int'(pos_x) - 3 + int'($urandom_range(0, 5));
            sy = int'(pos_y) - 3 + int'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0 || sx < 0 || sx > 95) sx = int'($urandom_range(0, 95));
            if (sy < 0 || sy > 63) sy = int'($urandom_range(0, 63));
            pixel_index = 13'(sy * 96 + sx);
            mirror = 1'($urandom_range(0, 1));
            tint_en = 1'($urandom_range(0, 1));
            anim_req = $urandom_range(0, 15) == 0;
            anim_sel = 2'($urandom_range(0, 3));
            rst_n = $urandom_range(0, 199) != 0;
            tick;
            n_cmp++;
            if (rom_addr !== e_addr) begin
                n_err++; $display("FAIL rnd_addr i=%0d: addr=%0d want %0d", i, rom_addr, e_addr);
            end
            n_cmp++;
            if (pix_colour !== e_col || pix_opaque !== e_op) begin
                n_err++; $display("FAIL rnd_pix i=%0d: colour=%h opaque=%b want %h/%b", i, pix_colour, pix_opaque, e_col, e_op);
            end
            n_cmp++;
            if (cur_anim !== m_anim || int'(cur_frame) !== (m_age / 4) % 3) begin
                n_err++; $display("FAIL rnd_seq i=%0d: anim=%0d frame=%0d want %0d/%0d", i, cur_anim, cur_frame, m_anim, (m_age / 4) % 3);
            end
            n_cmp++;
            if (anim_done !== m_done) begin
                n_err++; $display("FAIL rnd_done i=%0d: done=%b want %b", i, anim_done, m_done);
            end
        end
        rst_n = 1'b1; anim_req = 1'b0;
    endtask

    initial begin
        test_reset;
        test_mapping;
        test_mirror_key;
        test_oneshot;
        test_priority;
        test_tint_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
